// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the latched request control fields.
package lsu_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
    } lsu_ctl_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the LSU: request legality check, load lane
// extraction with extension, and sub-word store merge into a read word.
module lsu_align
    import lsu_defs::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic            chk_we,
    input  logic [2:0]      chk_funct3,
    input  logic [XLEN-1:0] chk_addr,
    output logic            chk_err,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_data
);

    logic       legal;
    logic       misal;
    logic       oob;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        if (chk_we)
            legal = (chk_funct3 == F3_B) || (chk_funct3 == F3_H) || (chk_funct3 == F3_W);
        else
            legal = (chk_funct3 == F3_B) || (chk_funct3 == F3_H) || (chk_funct3 == F3_W) ||
                    (chk_funct3 == F3_BU) || (chk_funct3 == F3_HU);
        // funct3[1:0] is the access size for every legal encoding
        misal   = ((chk_funct3[1:0] == 2'b01) && chk_addr[0]) ||
                  ((chk_funct3[1:0] == 2'b10) && (chk_addr[1:0] != 2'b00));
        oob     = chk_addr >= XLEN'(MEM_BYTES);
        chk_err = !legal || misal || oob;
    end

    always_comb begin
        byte_v    = rdata[{lane, 3'b000} +: 8];
        half_v    = rdata[{lane[1], 4'b0000} +: 16];
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_H:    load_data = {{(XLEN-16){half_v[15]}}, half_v};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_v};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_v};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_data = rdata;
        case (funct3)
            F3_B:    store_data[{lane, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    store_data = wdata;
            default: store_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and a word-addressed data memory; sub-word
// stores are done as read-modify-write.
module load_store_unit
    import lsu_defs::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state, nxt;
    lsu_ctl_t        ctl_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic            chk_err;
    logic            acc;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] store_data;

    lsu_align #(.XLEN(XLEN), .MEM_BYTES(MEM_BYTES)) u_align (
        .chk_we     (req_we),
        .chk_funct3 (req_funct3),
        .chk_addr   (req_addr),
        .chk_err    (chk_err),
        .funct3     (ctl_q.funct3),
        .lane       (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (rdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    assign acc = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ctl_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= nxt;
            if (acc) begin
                ctl_q   <= '{we: req_we, funct3: req_funct3};
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= chk_err;
            end
            if (state == RD)
                rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        nxt        = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (acc) begin
                    if (chk_err)
                        nxt = RESP;
                    else if (req_we && (req_funct3 == F3_W))
                        nxt = WR;
                    else
                        nxt = RD;
                end
            end
            RD: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[XLEN-1:2], 2'b00};
                nxt      = ctl_q.we ? WR : RESP;
            end
            WR: begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[XLEN-1:2], 2'b00};
                mem_wdata = store_data;
                nxt       = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || ctl_q.we) ? '0 : load_data;
                if (resp_ready)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic against a byte-array reference memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .MEM_BYTES(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'(i) * 32'h9E3779B1;
    endfunction

    // word memory seen by the DUT
    logic [31:0] mem [0:255];
    logic        init_done = 1'b0;
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    // activity monitor
    int          rd_cnt = 0, wr_cnt = 0, bad_cnt = 0;
    logic [31:0] last_wa = '0, last_wd = '0;
    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) begin
            wr_cnt++;
            last_wa = mem_addr;
            last_wd = mem_wdata;
        end
        if ((mem_read && mem_write) || (mem_addr[1:0] != 2'b00)) bad_cnt++;
    end

    // reference model: byte-addressed memory
    logic [7:0] ref_mem [0:1023];

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] erd, output logic eerr,
                         output int elat, output int enrd, output int enwr);
        int          size;
        logic        legal;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        eerr  = !legal || (addr % size != 0) || (addr >= 1024);
        erd = '0; enrd = 0; enwr = 0; elat = 1;
        if (!eerr && we) begin
            for (int k = 0; k < size; k++) ref_mem[addr + k] = wdata[8*k +: 8];
            enwr = 1;
            enrd = (size < 4) ? 1 : 0;
            elat = (size < 4) ? 3 : 2;
        end else if (!eerr) begin
            v = '0;
            for (int k = 0; k < size; k++) v = v | (32'(ref_mem[addr + k]) << (8*k));
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
            erd  = v;
            enrd = 1;
            elat = 2;
        end
    endtask

    function automatic logic [31:0] ref_word(logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    // drives one transaction and returns what the DUT did
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] ord, output logic oerr,
                           output int olat, output int onrd, output int onwr, output int onbad);
        int r0, w0, b0, guard;
        guard = 0;
        while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        r0 = rd_cnt; w0 = wr_cnt; b0 = bad_cnt;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        olat = 1;
        while (!resp_valid && olat < 20) begin @(posedge clk); #1; olat++; end
        ord  = resp_rdata;
        oerr = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        onrd = rd_cnt - r0; onwr = wr_cnt - w0; onbad = bad_cnt - b0;
    endtask

    logic [31:0] o_rd, e_rd;
    logic        o_err, e_err;
    int          o_lat, o_nrd, o_nwr, o_bad, e_lat, e_nrd, e_nwr;

    task automatic test_reset;
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 10000",
                               {req_ready, resp_valid, resp_err, mem_read, mem_write});
        end
        n_cmp++;
        if ((mem_addr | mem_wdata | resp_rdata) !== 32'h0) begin
            n_fail++; $display("FAIL reset_data got %h/%h/%h want 0", mem_addr, mem_wdata, resp_rdata);
        end
    endtask

    task automatic test_sw_lw;
        model(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
        n_cmp++;
        if (o_err !== 1'b0 || o_lat !== 2) begin
            n_fail++; $display("FAIL sw_resp err=%b lat=%0d want err=0 lat=2", o_err, o_lat);
        end
        n_cmp++;
        if (o_nwr !== 1 || o_nrd !== 0 || last_wa !== 32'h10 || last_wd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sw_mem wr=%0d rd=%0d addr=%h data=%h want 1/0/10/deadbeef",
                               o_nwr, o_nrd, last_wa, last_wd);
        end
        model(1'b0, 3'd2, 32'h10, 32'h0, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1'b0, 3'd2, 32'h10, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
        n_cmp++;
        if (o_rd !== 32'hDEADBEEF || o_err !== 1'b0 || o_lat !== 2) begin
            n_fail++; $display("FAIL lw_resp data=%h err=%b lat=%0d want deadbeef/0/2", o_rd, o_err, o_lat);
        end
    endtask

    task automatic test_sb;
        model(1'b1, 3'd0, 32'h11, 32'hA5, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1'b1, 3'd0, 32'h11, 32'hA5, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
        n_cmp++;
        if (o_nrd !== 1 || o_nwr !== 1 || o_lat !== 3 || last_wd !== 32'hDEADA5EF) begin
            n_fail++; $display("FAIL sb_merge rd=%0d wr=%0d lat=%0d data=%h want 1/1/3/deada5ef",
                               o_nrd, o_nwr, o_lat, last_wd);
        end
        model(1'b0, 3'd0, 32'h11, 32'h0, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1'b0, 3'd0, 32'h11, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
        n_cmp++;
        if (o_rd !== 32'hFFFFFFA5) begin
            n_fail++; $display("FAIL lb got %h want ffffffa5", o_rd);
        end
        model(1'b0, 3'd4, 32'h11, 32'h0, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1'b0, 3'd4, 32'h11, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
        n_cmp++;
        if (o_rd !== 32'h000000A5) begin
            n_fail++; $display("FAIL lbu got %h want 000000a5", o_rd);
        end
    endtask

    task automatic test_sh;
        model(1'b1, 3'd1, 32'h12, 32'h8001, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1'b1, 3'd1, 32'h12, 32'h8001, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
        n_cmp++;
        if (last_wd !== 32'h8001A5EF || o_lat !== 3) begin
            n_fail++; $display("FAIL sh_merge data=%h lat=%0d want 8001a5ef/3", last_wd, o_lat);
        end
        model(1'b0, 3'd1, 32'h12, 32'h0, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1'b0, 3'd1, 32'h12, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
        n_cmp++;
        if (o_rd !== 32'hFFFF8001) begin
            n_fail++; $display("FAIL lh got %h want ffff8001", o_rd);
        end
        model(1'b0, 3'd5, 32'h12, 32'h0, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1'b0, 3'd5, 32'h12, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
        n_cmp++;
        if (o_rd !== 32'h00008001) begin
            n_fail++; $display("FAIL lhu got %h want 00008001", o_rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] ea [4];
        logic        ew [4];
        logic [2:0]  ef [4];
        ea = '{32'h13, 32'h21, 32'h400, 32'h20};
        ew = '{1'b0, 1'b1, 1'b0, 1'b0};
        ef = '{3'd2, 3'd1, 3'd2, 3'd3};
        for (int i = 0; i < 4; i++) begin
            run_txn(ew[i], ef[i], ea[i], 32'h12345678, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
            n_cmp++;
            if (o_err !== 1'b1 || o_rd !== 32'h0 || o_lat !== 1 || o_nrd !== 0 || o_nwr !== 0) begin
                n_fail++; $display("FAIL err_case%0d err=%b data=%h lat=%0d rd=%0d wr=%0d want 1/0/1/0/0",
                                   i, o_err, o_rd, o_lat, o_nrd, o_nwr);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        int          w0, r0, lat;
        model(1'b0, 3'd2, 32'h10, 32'h0, e_rd, e_err, e_lat, e_nrd, e_nwr);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        held = resp_rdata;
        n_cmp++;
        if (held !== e_rd || lat !== 2) begin
            n_fail++; $display("FAIL bp_first data=%h lat=%0d want %h/2", held, lat, e_rd);
        end
        r0 = rd_cnt; w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d valid=%b data=%h ready=%b want 1/%h/0",
                                   i, resp_valid, resp_rdata, req_ready, held);
            end
        end
        resp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_overlap req_ready=%b want 0", req_ready);
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || rd_cnt != r0 || wr_cnt != w0) begin
            n_fail++; $display("FAIL bp_release ready=%b mem_ops=%0d want 1/0",
                               req_ready, (rd_cnt - r0) + (wr_cnt - w0));
        end
        model(1'b0, 3'd0, 32'h12, 32'h0, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1'b0, 3'd0, 32'h12, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
        n_cmp++;
        if (o_rd !== e_rd || o_lat !== 2) begin
            n_fail++; $display("FAIL bp_next data=%h lat=%0d want %h/2", o_rd, o_lat, e_rd);
        end
    endtask

    task automatic test_reset_mid_rmw;
        int w0;
        w0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'h3C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h10) begin
            n_fail++; $display("FAIL rst_in_rd mem_read=%b addr=%h want 1/10", mem_read, mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, mem_read, mem_write} !== 4'b1000 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_async ctrl=%b addr=%h want 1000/0",
                               {req_ready, resp_valid, mem_read, mem_write}, mem_addr);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (wr_cnt != w0) begin
            n_fail++; $display("FAIL rst_no_write writes=%0d want 0", wr_cnt - w0);
        end
        model(1'b0, 3'd2, 32'h10, 32'h0, e_rd, e_err, e_lat, e_nrd, e_nwr);
        run_txn(1'b0, 3'd2, 32'h10, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
        n_cmp++;
        if (o_rd !== 32'h8001A5EF || o_rd !== e_rd) begin
            n_fail++; $display("FAIL rst_word got %h want 8001a5ef", o_rd);
        end
    endtask

    task automatic test_random;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        for (int i = 0; i < 80; i++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            addr  = 32'($urandom_range(0, 1100));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            if ($urandom_range(0, 15) == 0) addr = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            wdata = $urandom;
            model(we, f3, addr, wdata, e_rd, e_err, e_lat, e_nrd, e_nwr);
            run_txn(we, f3, addr, wdata, o_rd, o_err, o_lat, o_nrd, o_nwr, o_bad);
            n_cmp++;
            if (o_rd !== e_rd || o_err !== e_err || o_lat !== e_lat) begin
                n_fail++; $display("FAIL rnd%0d we=%b f3=%0d addr=%h got %h/%b/%0d want %h/%b/%0d",
                                   i, we, f3, addr, o_rd, o_err, o_lat, e_rd, e_err, e_lat);
            end
            n_cmp++;
            if (o_nrd !== e_nrd || o_nwr !== e_nwr || o_bad !== 0) begin
                n_fail++; $display("FAIL rnd%0d_mem rd=%0d wr=%0d bad=%0d want %0d/%0d/0",
                                   i, o_nrd, o_nwr, o_bad, e_nrd, e_nwr);
            end
            if (we && !e_err) begin
                n_cmp++;
                if (last_wd !== ref_word(addr) || last_wa !== {addr[31:2], 2'b00}) begin
                    n_fail++; $display("FAIL rnd%0d_wdata addr=%h data=%h want %h/%h",
                                       i, last_wa, last_wd, {addr[31:2], 2'b00}, ref_word(addr));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = init_word(i);
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 init_done = 1'b1;
        test_reset;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_sw_lw;
        test_sb;
        test_sh;
        test_errors;
        test_backpressure;
        test_reset_mid_rmw;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
